// File: rtl/multibyte_add_seq_if.sv
// Bus for multibyte_add_seq: operation request, result, flags and a debug view of the FSM state.
// Handshake: start is accepted on a rising edge only while ready=1; done is a one-cycle pulse
// with no backpressure, and result/flags are valid from that pulse until the next accepted start.
interface multibyte_add_seq_if #(
    parameter int BYTES = 4
);
    localparam int W = 8 * BYTES;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic [1:0]   dbg_state;

    modport master (
        output start, op_sub, a, b, cin,
        input  ready, done, result, cout, overflow, zero, dbg_state
    );

    modport slave (
        input  start, op_sub, a, b, cin,
        output ready, done, result, cout, overflow, zero, dbg_state
    );
endinterface

// File: rtl/multibyte_add_seq.sv
// Byte-serial W-bit add/subtract through one shared 8-bit adder, LSB byte first.
// Optional macro MULTIBYTE_ADD_SAT_EN adds unsigned saturation of the final result.
module FullAdder_8B (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [7:0] sum
);
    always_comb begin
        {cout, sum} = 9'(a) + 9'(b) + 9'(cin);
    end
endmodule

module multibyte_add_seq #(
    parameter int BYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    multibyte_add_seq_if.slave  bus
);
    localparam int W  = 8 * BYTES;
    localparam int IW = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          op_sub_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  result_q;
    logic          cout_q;
    logic          ovf_q;
    logic          zero_q;

    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [7:0]    sum_byte;
    logic          add_cout;
    logic          last_byte;
    logic [W-1:0]  res_next;
    logic [W-1:0]  res_final;
    logic          ovf_next;

    FullAdder_8B u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .cout (add_cout),
        .sum  (sum_byte)
    );

    // Byte select, result merge and flags for the byte currently in the adder.
    always_comb begin
        a_byte    = a_q[{idx_q, 3'b000} +: 8];
        b_byte    = b_q[{idx_q, 3'b000} +: 8] ^ {8{op_sub_q}};
        last_byte = (idx_q == IW'(BYTES - 1));
        res_next  = result_q;
        res_next[{idx_q, 3'b000} +: 8] = sum_byte;
        // On the last byte b_byte[7] is the sign bit of the effective B operand.
        ovf_next  = (a_q[W-1] == b_byte[7]) && (res_next[W-1] != a_q[W-1]);
`ifdef MULTIBYTE_ADD_SAT_EN
        if (!op_sub_q && add_cout) begin
            res_final = '1;
        end else if (op_sub_q && !add_cout) begin
            res_final = '0;
        end else begin
            res_final = res_next;
        end
`else
        res_final = res_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_byte) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags are captured together with the final byte so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_sub_q <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        op_sub_q <= bus.op_sub;
                        carry_q  <= bus.op_sub | bus.cin;
                        idx_q    <= '0;
                    end
                end
                RUN: begin
                    carry_q <= add_cout;
                    idx_q   <= idx_q + IW'(1);
                    if (last_byte) begin
                        result_q <= res_final;
                        cout_q   <= add_cout;
                        ovf_q    <= ovf_next;
                        zero_q   <= (res_final == '0);
                    end else begin
                        result_q <= res_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ready     = (state_q == IDLE);
        bus.done      = (state_q == DONE);
        bus.result    = result_q;
        bus.cout      = cout_q;
        bus.overflow  = ovf_q;
        bus.zero      = zero_q;
        bus.dbg_state = state_q;
    end
endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequencer that runs wide (BYTES x 8-bit) add/subtract operations through one shared FullAdder_8B instance.
- Processes one byte per cycle, least-significant byte first, with the carry held in a register between bytes.
- Sits in the ALU between the decode/control logic and the 8-bit adder datapath. It lets the 8-bit CPU handle 16/32-bit arithmetic without extra adder hardware.

Parameters:
- BYTES, 4, number of 8-bit slices per operand (legal 2..8); operand width W = 8*BYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when ready=1.
- op_sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b); latched with start.
- a  input  W  operand A; latched on accepted start.
- b  input  W  operand B; latched on accepted start.
- cin  input  1  carry-in for add; ignored for subtract.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when result/flags become valid.
- result  output  W  sum/difference; held until the next accepted start.
- cout  output  1  final carry out; for subtract 1 = no borrow.
- overflow  output  1  signed overflow of the W-bit operation.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, result=0, cout=0, overflow=0, zero=0. Byte index and carry register are cleared.
- Datapath: one internal FullAdder_8B instance, port order (a, b, cin, cout, sum).
  - Its a input is byte[idx] of latched A.
  - Its b input is byte[idx] of latched B, or its bitwise inverse when op_sub=1.
  - Its cin input is the carry register.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch a, b, op_sub.
  - Load carry register with cin (add) or 1 (subtract).
  - Set idx=0 and go to RUN.
- RUN:
  - Each cycle, write the adder sum into result byte[idx] and the adder cout into the carry register, then idx++.
  - After the idx=BYTES-1 cycle, go to DONE.
  - RUN lasts exactly BYTES cycles.
- DONE:
  - done=1 for exactly one cycle.
  - cout = carry register.
  - overflow = (A[W-1] == Beff[W-1]) && (result[W-1] != A[W-1]), where Beff is b or ~b.
  - zero = (result == 0).
  - Next state is IDLE.
- Latency: start accepted at edge N → done high during cycle N+BYTES+1. Back-to-back throughput is one op per BYTES+2 cycles.
- result and flags are not valid during RUN: partial bytes are visible and flags hold their previous values. Consumers use done.
- start while ready=0 is ignored and not queued. Operand changes after acceptance have no effect.
- start and rst high in the same cycle: rst wins.
- rst in any state: next cycle all outputs are at reset values; any in-flight operation is discarded.
- Wrap-around: results are modulo 2^W unless the optional feature is enabled.

Optional Feature:
- Macro MULTIBYTE_ADD_SAT_EN.
- Defined: unsigned saturation is applied in DONE.
  - Add with final carry=1 → result = all ones.
  - Subtract with final carry=0 (borrow) → result = 0.
  - cout and overflow still report the raw (unsaturated) values; zero reflects the saturated result.
- Undefined: result wraps modulo 2^W and no saturation logic is synthesized.

Test Plan:
- BYTES=4, add, a=0x000000FF, b=0x00000001, cin=0 → done exactly 5 cycles after the start edge, result=0x00000100, cout=0, overflow=0, zero=0.
- Add, a=0xFFFFFFFF, b=0x00000000, cin=1 → result=0x00000000, cout=1, zero=1, overflow=0. With MULTIBYTE_ADD_SAT_EN: result=0xFFFFFFFF, zero=0.
- Subtract, a=0x00000005, b=0x00000007 → result=0xFFFFFFFE, cout=0, overflow=0. With MULTIBYTE_ADD_SAT_EN: result=0x00000000, zero=1.
- Add, a=0x7FFFFFFF, b=0x00000001, cin=0 → result=0x80000000, overflow=1, cout=0. Subtract, a=0x80000000, b=0x00000001 → result=0x7FFFFFFF, overflow=1, cout=1.
- Start with a=0x11111111, b=0x22222222, then pulse start with different operands during RUN → ready=0 during RUN, second start ignored, result=0x33333333, a single done pulse.
- Assert rst in the second RUN cycle → next cycle ready=1, done=0, result=0. A following add 0x00000010+0x00000020 completes normally with result=0x00000030.
